// File: rtl/rf_wport_arbiter_if.sv
// Write-port bundle: pipeline write-back and long-latency unit requests in,
// regfile write and pending-register mask out.
interface rf_wport_arbiter_if;
   logic        pl_valid;
   logic        pl_ready;
   logic [3:0]  pl_we;
   logic [4:0]  pl_waddr;
   logic [31:0] pl_wdata;
   logic [31:0] pl_pc;
   logic        lu_valid;
   logic        lu_ready;
   logic [3:0]  lu_we;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic [31:0] lu_pc;
   logic [31:0] pend_mask;
   logic [3:0]  rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] rf_pc;

   modport master (
      output pl_valid, pl_we, pl_waddr, pl_wdata, pl_pc,
      output lu_valid, lu_we, lu_waddr, lu_wdata, lu_pc,
      input  pl_ready, lu_ready, pend_mask,
      input  rf_we, rf_waddr, rf_wdata, rf_pc
   );

   modport slave (
      input  pl_valid, pl_we, pl_waddr, pl_wdata, pl_pc,
      input  lu_valid, lu_we, lu_waddr, lu_wdata, lu_pc,
      output pl_ready, lu_ready, pend_mask,
      output rf_we, rf_waddr, rf_wdata, rf_pc
   );
endinterface

// File: rtl/rf_wport_arbiter.sv
// GPR write-port arbiter: pipeline write-back has priority, queued long-latency
// results are forced through after MAX_WAIT bypassed cycles.
module rf_wport_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input logic               clk,
   input logic               reset,
   rf_wport_arbiter_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int WW = $clog2(MAX_WAIT) + 1;

   logic [3:0]    mem_we    [DEPTH];
   logic [4:0]    mem_waddr [DEPTH];
   logic [31:0]   mem_wdata [DEPTH];
   logic [31:0]   mem_pc    [DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [WW-1:0] wait_cnt;

   logic [3:0]    rf_we;
   logic [4:0]    rf_waddr;
   logic [31:0]   rf_wdata;
   logic [31:0]   rf_pc;
   logic [31:0]   pend_mask;

   logic          empty;
   logic          full;
   logic          force_lu;
   logic          push;
   logic          grant_lu;
   logic          grant_pl;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign force_lu = (wait_cnt >= WW'(MAX_WAIT));
   assign push     = bus.lu_valid && !full;
   assign grant_lu = !empty && (force_lu || !bus.pl_valid);
   assign grant_pl = bus.pl_valid && !(force_lu && !empty);

   assign bus.pl_ready  = grant_pl;
   assign bus.lu_ready  = !full;
   assign bus.pend_mask = pend_mask;
   assign bus.rf_we     = rf_we;
   assign bus.rf_waddr  = rf_waddr;
   assign bus.rf_wdata  = rf_wdata;
   assign bus.rf_pc     = rf_pc;

   // An entry is live when its distance from the read pointer is below count;
   // the head being popped this cycle still contributes until the next edge.
   always_comb begin
      logic [PW-1:0] off;
      pend_mask = '0;
      off       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - rd_ptr;
         if ((CW'(off) < count) && (mem_we[i] != 4'b0000) && (mem_waddr[i] != 5'd0))
            pend_mask = pend_mask | (32'd1 << mem_waddr[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_we[wr_ptr]    <= bus.lu_we;
         mem_waddr[wr_ptr] <= bus.lu_waddr;
         mem_wdata[wr_ptr] <= bus.lu_wdata;
         mem_pc[wr_ptr]    <= bus.lu_pc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         wait_cnt <= '0;
         rf_we    <= 4'b0000;
         rf_waddr <= 5'd0;
         rf_wdata <= 32'd0;
         rf_pc    <= 32'd0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (grant_lu)
            rd_ptr <= rd_ptr + 1'b1;

         case ({push, grant_lu})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (empty || grant_lu)
            wait_cnt <= '0;
         else if (grant_pl && !force_lu)
            wait_cnt <= wait_cnt + 1'b1;

         // Writes to r0 still consume their slot but never reach the regfile.
         if (grant_lu) begin
            rf_we    <= (mem_waddr[rd_ptr] == 5'd0) ? 4'b0000 : mem_we[rd_ptr];
            rf_waddr <= mem_waddr[rd_ptr];
            rf_wdata <= mem_wdata[rd_ptr];
            rf_pc    <= mem_pc[rd_ptr];
         end else if (grant_pl) begin
            rf_we    <= (bus.pl_waddr == 5'd0) ? 4'b0000 : bus.pl_we;
            rf_waddr <= bus.pl_waddr;
            rf_wdata <= bus.pl_wdata;
            rf_pc    <= bus.pl_pc;
         end else begin
            rf_we    <= 4'b0000;
         end
      end
   end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: reset, PL-only, LU queueing, starvation,
// full FIFO ordering, r0 writes and reset mid-burst.
module tb_rf_wport_arbiter;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   rf_wport_arbiter_if bus();

   rf_wport_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic idle();
      bus.pl_valid = 1'b0; bus.pl_we = 4'h0; bus.pl_waddr = 5'd0;
      bus.pl_wdata = 32'd0; bus.pl_pc = 32'd0;
      bus.lu_valid = 1'b0; bus.lu_we = 4'h0; bus.lu_waddr = 5'd0;
      bus.lu_wdata = 32'd0; bus.lu_pc = 32'd0;
   endtask

   task automatic set_pl(input logic [3:0] we, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] pc);
      bus.pl_valid = 1'b1; bus.pl_we = we; bus.pl_waddr = a;
      bus.pl_wdata = d; bus.pl_pc = pc;
   endtask

   task automatic set_lu(input logic [3:0] we, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] pc);
      bus.lu_valid = 1'b1; bus.lu_we = we; bus.lu_waddr = a;
      bus.lu_wdata = d; bus.lu_pc = pc;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus.rf_we !== 4'h0) begin failures++; $display("FAIL reset_rf_we actual=%0h required=0", bus.rf_we); end
      checks++; if (bus.rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_rf_waddr actual=%0h required=0", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 32'd0) begin failures++; $display("FAIL reset_rf_wdata actual=%0h required=0", bus.rf_wdata); end
      checks++; if (bus.rf_pc !== 32'd0) begin failures++; $display("FAIL reset_rf_pc actual=%0h required=0", bus.rf_pc); end
      checks++; if (bus.pend_mask !== 32'd0) begin failures++; $display("FAIL reset_pend_mask actual=%0h required=0", bus.pend_mask); end
      checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL reset_lu_ready actual=%0b required=1", bus.lu_ready); end
      checks++; if (bus.pl_ready !== 1'b0) begin failures++; $display("FAIL reset_pl_ready actual=%0b required=0", bus.pl_ready); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_pl_only();
      @(negedge clk);
      set_pl(4'hF, 5'd5, 32'h0000_1234, 32'hBFC0_0000);
      #1;
      checks++; if (bus.pl_ready !== 1'b1) begin failures++; $display("FAIL pl_only_ready actual=%0b required=1", bus.pl_ready); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus.rf_we !== 4'hF) begin failures++; $display("FAIL pl_only_we actual=%0h required=f", bus.rf_we); end
      checks++; if (bus.rf_waddr !== 5'd5) begin failures++; $display("FAIL pl_only_waddr actual=%0d required=5", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 32'h0000_1234) begin failures++; $display("FAIL pl_only_wdata actual=%0h required=1234", bus.rf_wdata); end
      checks++; if (bus.rf_pc !== 32'hBFC0_0000) begin failures++; $display("FAIL pl_only_pc actual=%0h required=bfc00000", bus.rf_pc); end
      @(negedge clk);
      #1;
      checks++; if (bus.rf_we !== 4'h0) begin failures++; $display("FAIL pl_only_one_cycle actual=%0h required=0", bus.rf_we); end
   endtask

   task automatic test_lu_push();
      @(negedge clk);
      set_lu(4'hF, 5'd8, 32'hA5A5_0008, 32'h8000_0100);
      #1;
      checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL lu_push_ready actual=%0b required=1", bus.lu_ready); end
      checks++; if (bus.pend_mask !== 32'd0) begin failures++; $display("FAIL lu_push_pend_before actual=%0h required=0", bus.pend_mask); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus.pend_mask !== 32'h0000_0100) begin failures++; $display("FAIL lu_push_pend_queued actual=%0h required=100", bus.pend_mask); end
      checks++; if (bus.rf_we !== 4'h0) begin failures++; $display("FAIL lu_push_no_bypass actual=%0h required=0", bus.rf_we); end
      @(negedge clk);
      #1;
      checks++; if (bus.rf_we !== 4'hF) begin failures++; $display("FAIL lu_push_we actual=%0h required=f", bus.rf_we); end
      checks++; if (bus.rf_waddr !== 5'd8) begin failures++; $display("FAIL lu_push_waddr actual=%0d required=8", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 32'hA5A5_0008) begin failures++; $display("FAIL lu_push_wdata actual=%0h required=a5a50008", bus.rf_wdata); end
      checks++; if (bus.rf_pc !== 32'h8000_0100) begin failures++; $display("FAIL lu_push_pc actual=%0h required=80000100", bus.rf_pc); end
      checks++; if (bus.pend_mask !== 32'd0) begin failures++; $display("FAIL lu_push_pend_after actual=%0h required=0", bus.pend_mask); end
   endtask

   task automatic test_starvation();
      @(negedge clk);
      set_pl(4'hF, 5'd1, 32'h0000_1000, 32'h8000_1000);
      set_lu(4'hF, 5'd9, 32'h0000_9999, 32'h8000_9000);
      #1;
      checks++; if (bus.pl_ready !== 1'b1) begin failures++; $display("FAIL starve_push_cycle_ready actual=%0b required=1", bus.pl_ready); end
      @(negedge clk);
      bus.lu_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.pl_wdata = 32'h0000_1000 + 32'(k + 1);
         #1;
         checks++; if (bus.pl_ready !== 1'b1) begin failures++; $display("FAIL starve_pl_grant_%0d actual=%0b required=1", k, bus.pl_ready); end
         checks++; if (bus.pend_mask !== 32'h0000_0200) begin failures++; $display("FAIL starve_pend_%0d actual=%0h required=200", k, bus.pend_mask); end
         @(negedge clk);
      end
      #1;
      checks++; if (bus.pl_ready !== 1'b0) begin failures++; $display("FAIL starve_forced actual=%0b required=0", bus.pl_ready); end
      checks++; if (bus.rf_wdata !== 32'h0000_1004) begin failures++; $display("FAIL starve_last_pl_data actual=%0h required=1004", bus.rf_wdata); end
      @(negedge clk);
      #1;
      checks++; if (bus.rf_waddr !== 5'd9) begin failures++; $display("FAIL starve_lu_waddr actual=%0d required=9", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 32'h0000_9999) begin failures++; $display("FAIL starve_lu_wdata actual=%0h required=9999", bus.rf_wdata); end
      checks++; if (bus.pl_ready !== 1'b1) begin failures++; $display("FAIL starve_pl_resume actual=%0b required=1", bus.pl_ready); end
      checks++; if (bus.pend_mask !== 32'd0) begin failures++; $display("FAIL starve_pend_clear actual=%0h required=0", bus.pend_mask); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus.rf_waddr !== 5'd1) begin failures++; $display("FAIL starve_pl_after actual=%0d required=1", bus.rf_waddr); end
   endtask

   task automatic test_full();
      @(negedge clk);
      set_pl(4'hF, 5'd2, 32'h0000_2000, 32'h8000_2000);
      set_lu(4'hF, 5'd10, 32'h0000_00A0, 32'h8000_A000);
      @(negedge clk);
      set_lu(4'hF, 5'd11, 32'h0000_00B0, 32'h8000_B000);
      #1;
      checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL full_second_ready actual=%0b required=1", bus.lu_ready); end
      @(negedge clk);
      set_lu(4'hF, 5'd12, 32'h0000_00C0, 32'h8000_C000);
      #1;
      checks++; if (bus.lu_ready !== 1'b0) begin failures++; $display("FAIL full_third_ready actual=%0b required=0", bus.lu_ready); end
      checks++; if (bus.pend_mask !== 32'h0000_0C00) begin failures++; $display("FAIL full_pend actual=%0h required=c00", bus.pend_mask); end
      @(negedge clk);
      #1;
      checks++; if (bus.lu_ready !== 1'b0) begin failures++; $display("FAIL full_hold_ready actual=%0b required=0", bus.lu_ready); end
      @(negedge clk);
      #1;
      checks++; if (bus.pl_ready !== 1'b1) begin failures++; $display("FAIL full_pl_fourth actual=%0b required=1", bus.pl_ready); end
      @(negedge clk);
      #1;
      checks++; if (bus.pl_ready !== 1'b0) begin failures++; $display("FAIL full_forced actual=%0b required=0", bus.pl_ready); end
      checks++; if (bus.lu_ready !== 1'b0) begin failures++; $display("FAIL full_no_bypass_push actual=%0b required=0", bus.lu_ready); end
      @(negedge clk);
      #1;
      checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop_ready actual=%0b required=1", bus.lu_ready); end
      checks++; if (bus.rf_waddr !== 5'd10) begin failures++; $display("FAIL full_retire_first actual=%0d required=10", bus.rf_waddr); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus.rf_waddr !== 5'd2) begin failures++; $display("FAIL full_pl_between actual=%0d required=2", bus.rf_waddr); end
      checks++; if (bus.pend_mask !== 32'h0000_1800) begin failures++; $display("FAIL full_pend_after_push actual=%0h required=1800", bus.pend_mask); end
      @(negedge clk);
      #1;
      checks++; if (bus.rf_waddr !== 5'd11) begin failures++; $display("FAIL full_retire_second actual=%0d required=11", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 32'h0000_00B0) begin failures++; $display("FAIL full_retire_second_data actual=%0h required=b0", bus.rf_wdata); end
      @(negedge clk);
      #1;
      checks++; if (bus.rf_waddr !== 5'd12) begin failures++; $display("FAIL full_retire_third actual=%0d required=12", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 32'h0000_00C0) begin failures++; $display("FAIL full_retire_third_data actual=%0h required=c0", bus.rf_wdata); end
      checks++; if (bus.pend_mask !== 32'd0) begin failures++; $display("FAIL full_pend_drained actual=%0h required=0", bus.pend_mask); end
      @(negedge clk);
      #1;
      checks++; if (bus.rf_we !== 4'h0) begin failures++; $display("FAIL full_idle_we actual=%0h required=0", bus.rf_we); end
   endtask

   task automatic test_waddr0();
      @(negedge clk);
      set_pl(4'hF, 5'd0, 32'h0000_0077, 32'h8000_0770);
      set_lu(4'hF, 5'd0, 32'h0000_0088, 32'h8000_0880);
      #1;
      checks++; if (bus.pl_ready !== 1'b1) begin failures++; $display("FAIL r0_pl_ready actual=%0b required=1", bus.pl_ready); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (bus.rf_we !== 4'h0) begin failures++; $display("FAIL r0_pl_we actual=%0h required=0", bus.rf_we); end
      checks++; if (bus.rf_wdata !== 32'h0000_0077) begin failures++; $display("FAIL r0_pl_wdata actual=%0h required=77", bus.rf_wdata); end
      checks++; if (bus.pend_mask !== 32'd0) begin failures++; $display("FAIL r0_pend actual=%0h required=0", bus.pend_mask); end
      @(negedge clk);
      #1;
      checks++; if (bus.rf_we !== 4'h0) begin failures++; $display("FAIL r0_lu_we actual=%0h required=0", bus.rf_we); end
      checks++; if (bus.rf_wdata !== 32'h0000_0088) begin failures++; $display("FAIL r0_lu_wdata actual=%0h required=88", bus.rf_wdata); end
      checks++; if (bus.rf_pc !== 32'h8000_0880) begin failures++; $display("FAIL r0_lu_pc actual=%0h required=80000880", bus.rf_pc); end
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clk);
      set_pl(4'hF, 5'd3, 32'h0000_3000, 32'h8000_3000);
      set_lu(4'hF, 5'd13, 32'h0000_00D0, 32'h8000_D000);
      @(negedge clk);
      set_lu(4'hF, 5'd14, 32'h0000_00E0, 32'h8000_E000);
      @(negedge clk);
      bus.lu_valid = 1'b0;
      #1;
      checks++; if (bus.lu_ready !== 1'b0) begin failures++; $display("FAIL midrst_full_before actual=%0b required=0", bus.lu_ready); end
      reset = 1'b1;
      idle();
      #1;
      checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL midrst_lu_ready actual=%0b required=1", bus.lu_ready); end
      checks++; if (bus.pend_mask !== 32'd0) begin failures++; $display("FAIL midrst_pend actual=%0h required=0", bus.pend_mask); end
      checks++; if (bus.rf_we !== 4'h0) begin failures++; $display("FAIL midrst_rf_we actual=%0h required=0", bus.rf_we); end
      checks++; if (bus.rf_waddr !== 5'd0) begin failures++; $display("FAIL midrst_rf_waddr actual=%0d required=0", bus.rf_waddr); end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         checks++; if (bus.rf_we !== 4'h0) begin failures++; $display("FAIL midrst_no_write_%0d actual=%0h required=0", k, bus.rf_we); end
         checks++; if (bus.pend_mask !== 32'd0) begin failures++; $display("FAIL midrst_pend_%0d actual=%0h required=0", k, bus.pend_mask); end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      idle();
      test_reset();
      test_pl_only();
      test_lu_push();
      test_starvation();
      test_full();
      test_waddr0();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
